// File: rtl/bilinear_interp_pipe_if.sv
// Valid/ready beat bundle for the bilinear interpolator: fetch-side inputs and
// writeback-side outputs, all lanes packed at lane k -> [k*W +: W].
interface bilinear_interp_pipe_if #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8,
    parameter int LANES  = 1
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_mode;
    logic [LANES*PIX_W-1:0]    I00;
    logic [LANES*PIX_W-1:0]    I10;
    logic [LANES*PIX_W-1:0]    I01;
    logic [LANES*PIX_W-1:0]    I11;
    logic [LANES*FRAC_W-1:0]   alpha;
    logic [LANES*FRAC_W-1:0]   beta;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*PIX_W-1:0]    pixel_out;

    modport master (
        output in_valid, in_mode, I00, I10, I01, I11, alpha, beta, out_ready,
        input  in_ready, out_valid, pixel_out
    );

    modport slave (
        input  in_valid, in_mode, I00, I10, I01, I11, alpha, beta, out_ready,
        output in_ready, out_valid, pixel_out
    );
endinterface

// File: rtl/bilinear_interp_pipe.sv
// Three-stage multi-lane bilinear / nearest-neighbour interpolator with
// valid/ready backpressure and a wrapping count of delivered output beats.
module bilinear_interp_pipe #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8,
    parameter int LANES  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    bilinear_interp_pipe_if.slave bus,
    output logic [CNT_W-1:0]      beat_count
);
    localparam int A_W = PIX_W + FRAC_W + 2;
    localparam int V_W = PIX_W + 2*FRAC_W + 3;
    localparam logic signed [V_W-1:0] HALF    = {{(V_W-1){1'b0}}, 1'b1} <<< (2*FRAC_W-1);
    localparam logic signed [V_W-1:0] PIX_MAX = {{(V_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

    function automatic logic signed [A_W-1:0] lerp_h(input logic [PIX_W-1:0] p0,
                                                     input logic [PIX_W-1:0] p1,
                                                     input logic [FRAC_W-1:0] w);
        logic signed [A_W-1:0] s0, s1, ws;
        s0 = signed'({{(A_W-PIX_W){1'b0}}, p0});
        s1 = signed'({{(A_W-PIX_W){1'b0}}, p1});
        ws = signed'({{(A_W-FRAC_W){1'b0}}, w});
        return (s0 <<< FRAC_W) + ws * (s1 - s0);
    endfunction

    function automatic logic signed [V_W-1:0] lerp_v(input logic signed [A_W-1:0] a,
                                                     input logic signed [A_W-1:0] b,
                                                     input logic [FRAC_W-1:0] w);
        logic signed [V_W-1:0] s0, s1, ws;
        s0 = {{(V_W-A_W){a[A_W-1]}}, a};
        s1 = {{(V_W-A_W){b[A_W-1]}}, b};
        ws = signed'({{(V_W-FRAC_W){1'b0}}, w});
        return (s0 <<< FRAC_W) + ws * (s1 - s0);
    endfunction

    // Nearest pixel is scaled to Q.F so the following stages pass it through unchanged.
    function automatic logic signed [A_W-1:0] nearest(input logic [PIX_W-1:0] p00,
                                                      input logic [PIX_W-1:0] p10,
                                                      input logic [PIX_W-1:0] p01,
                                                      input logic [PIX_W-1:0] p11,
                                                      input logic x,
                                                      input logic y);
        logic [PIX_W-1:0] sel;
        sel = x ? (y ? p11 : p10) : (y ? p01 : p00);
        return signed'({{(A_W-PIX_W){1'b0}}, sel}) <<< FRAC_W;
    endfunction

    function automatic logic signed [V_W-1:0] round_half_up(input logic signed [V_W-1:0] v);
        logic signed [V_W-1:0] s;
        s = v + HALF;
        return s >>> (2*FRAC_W);
    endfunction

    function automatic logic [PIX_W-1:0] saturate(input logic signed [V_W-1:0] r);
        if (r[V_W-1])
            return '0;
        else if (r > PIX_MAX)
            return '1;
        else
            return r[PIX_W-1:0];
    endfunction

    logic                    vld_p0_q, vld_p0_d;
    logic                    vld_p1_q, vld_p1_d;
    logic                    vld_p2_q, vld_p2_d;
    logic                    ready_en_q;
    logic [CNT_W-1:0]        beat_count_q, beat_count_d;
    logic [LANES*PIX_W-1:0]  pixel_p2_q, pixel_p2_d;
    logic signed [A_W-1:0]   a_p0_q [LANES];
    logic signed [A_W-1:0]   a_p0_d [LANES];
    logic signed [A_W-1:0]   b_p0_q [LANES];
    logic signed [A_W-1:0]   b_p0_d [LANES];
    logic [FRAC_W-1:0]       beta_p0_q [LANES];
    logic [FRAC_W-1:0]       beta_p0_d [LANES];
    logic signed [V_W-1:0]   v_p1_q [LANES];
    logic signed [V_W-1:0]   v_p1_d [LANES];

    logic en_p0, en_p1, en_p2, in_ready, in_fire, out_fire;

    // Stage enables ripple back from the output so bubbles collapse.
    always_comb begin
        en_p2        = !vld_p2_q || bus.out_ready;
        en_p1        = !vld_p1_q || en_p2;
        en_p0        = !vld_p0_q || en_p1;
        in_ready     = ready_en_q && en_p0;
        in_fire      = bus.in_valid && in_ready;
        out_fire     = vld_p2_q && bus.out_ready;
        vld_p0_d     = en_p0 ? in_fire  : vld_p0_q;
        vld_p1_d     = en_p1 ? vld_p0_q : vld_p1_q;
        vld_p2_d     = en_p2 ? vld_p1_q : vld_p2_q;
        beat_count_d = beat_count_q + CNT_W'(out_fire);
    end

    // S1: horizontal lerp (or nearest selection) per lane
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            a_p0_d[k]    = a_p0_q[k];
            b_p0_d[k]    = b_p0_q[k];
            beta_p0_d[k] = beta_p0_q[k];
            if (in_fire) begin
                beta_p0_d[k] = bus.beta[k*FRAC_W +: FRAC_W];
                if (bus.in_mode) begin
                    a_p0_d[k] = nearest(bus.I00[k*PIX_W +: PIX_W], bus.I10[k*PIX_W +: PIX_W],
                                        bus.I01[k*PIX_W +: PIX_W], bus.I11[k*PIX_W +: PIX_W],
                                        bus.alpha[k*FRAC_W + FRAC_W - 1],
                                        bus.beta[k*FRAC_W + FRAC_W - 1]);
                    b_p0_d[k] = a_p0_d[k];
                end else begin
                    a_p0_d[k] = lerp_h(bus.I00[k*PIX_W +: PIX_W], bus.I10[k*PIX_W +: PIX_W],
                                       bus.alpha[k*FRAC_W +: FRAC_W]);
                    b_p0_d[k] = lerp_h(bus.I01[k*PIX_W +: PIX_W], bus.I11[k*PIX_W +: PIX_W],
                                       bus.alpha[k*FRAC_W +: FRAC_W]);
                end
            end
        end
    end

    // S2: vertical lerp; S3: round half-up and saturate into the output register
    always_comb begin
        pixel_p2_d = pixel_p2_q;
        for (int k = 0; k < LANES; k++) begin
            v_p1_d[k] = v_p1_q[k];
            if (en_p1 && vld_p0_q)
                v_p1_d[k] = lerp_v(a_p0_q[k], b_p0_q[k], beta_p0_q[k]);
            if (en_p2 && vld_p1_q)
                pixel_p2_d[k*PIX_W +: PIX_W] = saturate(round_half_up(v_p1_q[k]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0_q     <= 1'b0;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            ready_en_q   <= 1'b0;
            beat_count_q <= '0;
            pixel_p2_q   <= '0;
        end else begin
            vld_p0_q     <= vld_p0_d;
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            ready_en_q   <= 1'b1;
            beat_count_q <= beat_count_d;
            pixel_p2_q   <= pixel_p2_d;
        end
    end

    // Datapath registers are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        a_p0_q    <= a_p0_d;
        b_p0_q    <= b_p0_d;
        beta_p0_q <= beta_p0_d;
        v_p1_q    <= v_p1_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p2_q;
    assign bus.pixel_out = pixel_p2_q;
    assign beat_count    = beat_count_q;
endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// Directed bench for bilinear_interp_pipe: a single-lane instance for vector,
// stall and throughput cases and a 4-lane/4-bit-counter instance for wrap and reset.
module tb_bilinear_interp_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] beat_count1;
    logic [3:0]  beat_count4;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    bilinear_interp_pipe_if #(.PIX_W(8), .FRAC_W(8), .LANES(1)) bus1 ();
    bilinear_interp_pipe_if #(.PIX_W(8), .FRAC_W(8), .LANES(4)) bus4 ();

    bilinear_interp_pipe #(.PIX_W(8), .FRAC_W(8), .LANES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .beat_count(beat_count1));
    bilinear_interp_pipe #(.PIX_W(8), .FRAC_W(8), .LANES(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .beat_count(beat_count4));

    typedef struct {
        string name;
        bit    mode;
        int    i00, i10, i01, i11, al, be;
        int    exp;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference result straight from the interpolation formula (F = 8).
    function automatic int golden(input bit m, input int i00, input int i10, input int i01,
                                  input int i11, input int al, input int be);
        int a, b, v, r;
        if (m) begin
            if (al >= 128) return (be >= 128) ? i11 : i10;
            else           return (be >= 128) ? i01 : i00;
        end
        a = i00*256 + al*(i10 - i00);
        b = i01*256 + al*(i11 - i01);
        v = a*256 + be*(b - a);
        r = (v + 32768) >>> 16;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic drive1(input bit m, input int i00, input int i10, input int i01,
                          input int i11, input int al, input int be);
        bus1.in_mode = m;
        bus1.I00 = 8'(i00); bus1.I10 = 8'(i10);
        bus1.I01 = 8'(i01); bus1.I11 = 8'(i11);
        bus1.alpha = 8'(al); bus1.beta = 8'(be);
    endtask

    vec_t        vecs[12];
    int          got_q[$];
    logic [31:0] exp_q[$];

    initial begin
        int          nout, bad, low_rdy, sent, recv, cyc, hold_bad, seen;
        bit          dsent, pending, prev_stall;
        logic [31:0] exp_w, prev_pix, p00, p10, p01, p11, al4, be4;
        bit          m4;

        vecs[0]  = '{"half_blend",   0,   0, 255,   0, 255, 'h80, 'h00, 128};
        vecs[1]  = '{"round_27p5",   0,  10,  20,  30,  40, 'h40, 'hC0,  28};
        vecs[2]  = '{"nn_top_right", 1,   1,   2,   3,   4, 'h80, 'h00,   2};
        vecs[3]  = '{"nn_bot_left",  1,   1,   2,   3,   4, 'h7F, 'hFF,   3};
        vecs[4]  = '{"zero_weights", 0, 100,  50,  25,  75, 'h00, 'h00, 100};
        vecs[5]  = '{"max_weights",  0,   0, 255,   0, 255, 'hFF, 'hFF, 254};
        vecs[6]  = '{"nn_bot_right", 1,  10,  20,  30,  40, 'hFF, 'hFF,  40};
        vecs[7]  = '{"nn_y_only",    1,  10,  20,  30,  40, 'h00, 'h80,  30};
        vecs[8]  = '{"all_255",      0, 255, 255, 255, 255, 'h37, 'h99, 255};
        vecs[9]  = '{"half_lsb_up",  0,   0,   1,   0,   1, 'h80, 'h00,   1};
        vecs[10] = '{"quarter_down", 0,   0,   0,   0,   1, 'h80, 'h80,   0};
        vecs[11] = '{"neg_slopes",   0, 200, 100,  50,   0, 'h80, 'h80,  88};

        bus1.in_valid = 0; bus1.out_ready = 1; drive1(0, 0, 0, 0, 0, 0, 0);
        bus4.in_valid = 0; bus4.out_ready = 1; bus4.in_mode = 0;
        bus4.I00 = '0; bus4.I10 = '0; bus4.I01 = '0; bus4.I11 = '0;
        bus4.alpha = '0; bus4.beta = '0;

        // Reset state and ready release
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus1.out_valid, 0);
        check("rst_pixel_out", bus1.pixel_out, 0);
        check("rst_beat_count", beat_count1, 0);
        check("rst_in_ready", bus1.in_ready, 0);
        rst = 0;
        #1 check("in_ready_before_edge", bus1.in_ready, 0);
        @(posedge clk); #1;
        check("in_ready_after_edge", bus1.in_ready, 1);

        // Directed vectors, one at a time, checking latency and value
        for (int i = 0; i < 12; i++) begin
            drive1(vecs[i].mode, vecs[i].i00, vecs[i].i10, vecs[i].i01,
                   vecs[i].i11, vecs[i].al, vecs[i].be);
            bus1.in_valid = 1;
            @(posedge clk); #1;
            bus1.in_valid = 0;
            @(posedge clk); #1;
            check({vecs[i].name, "_early"}, bus1.out_valid, 0);
            @(posedge clk); #1;
            check(vecs[i].name, bus1.out_valid ? int'(bus1.pixel_out) : -1, vecs[i].exp);
        end
        @(posedge clk); #1;
        check("beat_count_12", beat_count1, 12);

        // Backpressure: A,B,C fill the pipe, D waits until release
        bus1.out_ready = 0;
        drive1(1, 11, 0, 0, 0, 0, 0); bus1.in_valid = 1;
        #1 check("stall_accept_a", bus1.in_ready, 1);
        @(posedge clk); #1;
        drive1(1, 22, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive1(1, 33, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive1(1, 44, 0, 0, 0, 0, 0);
        check("stall_in_ready_after_c", bus1.in_ready, 0);
        check("stall_head_a", bus1.out_valid ? int'(bus1.pixel_out) : -1, 11);
        hold_bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (!bus1.out_valid || bus1.pixel_out != 8'd11 || bus1.in_ready) hold_bad++;
        end
        check("stall_hold_stable", hold_bad, 0);
        bus1.out_ready = 1;
        #1 check("stall_release_ready", bus1.in_ready, 1);
        dsent = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus1.out_valid) got_q.push_back(int'(bus1.pixel_out));
            if (bus1.in_valid && bus1.in_ready) dsent = 1;
            @(posedge clk); #1;
            if (dsent) bus1.in_valid = 0;
        end
        check("stall_out_count", got_q.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("stall_order_%0d", k), (k < got_q.size()) ? got_q[k] : -1, 11*(k+1));
        check("beat_count_16", beat_count1, 16);

        // Throughput: 1000 back-to-back beats of flat 200 pixels
        rst = 1; #2 rst = 0;
        @(posedge clk); #1;
        nout = 0; bad = 0; low_rdy = 0;
        for (int c = 0; c < 1002; c++) begin
            drive1(0, 200, 200, 200, 200, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            bus1.in_valid = (c < 1000);
            #1 if (bus1.in_valid && !bus1.in_ready) low_rdy++;
            @(posedge clk); #1;
            if (bus1.out_valid) begin
                nout++;
                if (bus1.pixel_out != 8'd200) bad++;
            end
        end
        bus1.in_valid = 0;
        @(posedge clk); #1;
        check("tput_values", bad, 0);
        check("tput_outputs_in_window", nout, 1000);
        check("tput_in_ready_low", low_rdy, 0);
        check("tput_beat_count", beat_count1, 1000);
        check("tput_drained", bus1.out_valid, 0);

        // Four lanes, random gaps and random out_ready, counter wrap
        sent = 0; recv = 0; cyc = 0; pending = 0; prev_stall = 0; hold_bad = 0;
        exp_w = '0; prev_pix = '0;
        p00 = '0; p10 = '0; p01 = '0; p11 = '0; al4 = '0; be4 = '0; m4 = 0;
        while ((sent < 17 || recv < 17) && cyc < 400) begin
            if (!pending && sent < 17) begin
                p00 = $urandom; p10 = $urandom; p01 = $urandom; p11 = $urandom;
                al4 = $urandom; be4 = $urandom; m4 = ($urandom_range(0, 3) == 0);
                for (int l = 0; l < 4; l++)
                    exp_w[l*8 +: 8] = 8'(golden(m4, p00[l*8 +: 8], p10[l*8 +: 8], p01[l*8 +: 8],
                                                p11[l*8 +: 8], al4[l*8 +: 8], be4[l*8 +: 8]));
                bus4.I00 = p00; bus4.I10 = p10; bus4.I01 = p01; bus4.I11 = p11;
                bus4.alpha = al4; bus4.beta = be4; bus4.in_mode = m4;
                pending = 1;
            end
            bus4.in_valid  = pending && ($urandom_range(0, 3) != 0);
            bus4.out_ready = $urandom_range(0, 1);
            #1;
            if (prev_stall && (!bus4.out_valid || bus4.pixel_out != prev_pix)) hold_bad++;
            prev_stall = bus4.out_valid && !bus4.out_ready;
            prev_pix   = bus4.pixel_out;
            if (bus4.in_valid && bus4.in_ready) begin
                exp_q.push_back(exp_w);
                sent++;
                pending = 0;
            end
            if (bus4.out_valid && bus4.out_ready) begin
                if (exp_q.size() == 0)
                    check($sformatf("lanes4_extra_beat_%0d", recv), 1, 0);
                else
                    check($sformatf("lanes4_beat_%0d", recv), bus4.pixel_out, exp_q.pop_front());
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus4.in_valid = 0; bus4.out_ready = 1;
        check("lanes4_sent", sent, 17);
        check("lanes4_received", recv, 17);
        check("lanes4_stall_hold", hold_bad, 0);
        check("lanes4_count_wrap", beat_count4, 1);

        // Asynchronous reset with beats in flight
        bus4.in_valid = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1;
        #1;
        check("midrst_out_valid", bus4.out_valid, 0);
        check("midrst_beat_count", beat_count4, 0);
        bus4.in_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus4.out_valid) seen++;
        end
        check("midrst_no_partial_output", seen, 0);
        check("midrst_count_stays_0", beat_count4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
